// File: rtl/uart_tx_fifo.sv
// UART transmitter with a power-of-two TX FIFO in front of it.
// Each frame is start, N data bits LSB first, optional parity, then M stop bits.
module uart_tx_fifo #(
    parameter int N           = 8,
    parameter int M           = 1,
    parameter int PARITY_MODE = 0,
    parameter int BAUD_RATE   = 9600,
    parameter int CLK_FREQ    = 50000000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [N-1:0]                data_in,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic                        tx,
    output logic                        busy
);
    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BCW = $clog2(N);

    localparam logic [CW-1:0]  DIV_M1     = CW'(DIV - 1);
    localparam logic [BCW-1:0] LAST_DATA  = BCW'(N - 1);
    localparam logic [BCW-1:0] LAST_STOP  = BCW'(M - 1);
    localparam logic [AW:0]    DEPTH      = (AW + 1)'(FIFO_DEPTH);
    localparam bit             HAS_PARITY = (PARITY_MODE != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [N-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [N-1:0]   head;
    logic           push, pop;

    state_t         state, state_next;
    logic [CW-1:0]  baud_cnt, baud_next;
    logic [BCW-1:0] bit_cnt, bit_next;
    logic [N-1:0]   shift_q, shift_next;
    logic           par_q;
    logic           tx_next;
    logic           bit_done;

    assign full     = (fifo_count == DEPTH);
    assign empty    = (fifo_count == '0);
    assign push     = wr_en && !full;
    assign head     = mem[rd_ptr];
    assign busy     = (state != IDLE);
    assign bit_done = (baud_cnt == '0);

    // NOTE: the storage array has no reset; empty/full come from the reset count, so stale words are never read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= wr_en && full;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can leave a value held (no latches).
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_q;
        tx_next    = tx;
        pop        = 1'b0;

        if (state != IDLE)
            baud_next = bit_done ? DIV_M1 : baud_cnt - CW'(1);

        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = START;
                    pop        = 1'b1;
                    baud_next  = DIV_M1;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next = DATA;
                    bit_next   = '0;
                    tx_next    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt == LAST_DATA) begin
                        bit_next = '0;
                        if (HAS_PARITY) begin
                            state_next = PARITY;
                            tx_next    = par_q;
                        end else begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_next   = bit_cnt + BCW'(1);
                        shift_next = shift_q >> 1;
                        tx_next    = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                    bit_next   = '0;
                    tx_next    = 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (bit_cnt == LAST_STOP) begin
                        bit_next = '0;
                        // Chain straight into the next frame when more data is waiting.
                        if (!empty) begin
                            state_next = START;
                            pop        = 1'b1;
                            tx_next    = 1'b0;
                        end else begin
                            state_next = IDLE;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_next = bit_cnt + BCW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase

        if (pop)
            shift_next = head;
    end

    // NOTE: registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shift_q  <= shift_next;
            tx       <= tx_next;
            if (pop)
                par_q <= (PARITY_MODE == 2) ? ~^head : ^head;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: five parameterisations driven from shared stimulus,
// DIV = 10 everywhere; frame tables plus hand-written back-to-back, FIFO-full and reset cases.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] din = 8'h00;

    logic [4:0] tx_v, busy_v, full_v, empty_v, ovf_v;
    logic [3:0] cnt8 [4];
    logic [2:0] cnt4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // 0: defaults, 1: even parity, 2: odd parity, 3: two stop bits, 4: depth 4
    uart_tx_fifo #(.N(8), .M(1), .PARITY_MODE(0), .BAUD_RATE(5000000), .CLK_FREQ(50000000), .FIFO_DEPTH(8)) u0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(din), .full(full_v[0]), .empty(empty_v[0]),
        .fifo_count(cnt8[0]), .overflow(ovf_v[0]), .tx(tx_v[0]), .busy(busy_v[0]));
    uart_tx_fifo #(.N(8), .M(1), .PARITY_MODE(1), .BAUD_RATE(5000000), .CLK_FREQ(50000000), .FIFO_DEPTH(8)) u1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(din), .full(full_v[1]), .empty(empty_v[1]),
        .fifo_count(cnt8[1]), .overflow(ovf_v[1]), .tx(tx_v[1]), .busy(busy_v[1]));
    uart_tx_fifo #(.N(8), .M(1), .PARITY_MODE(2), .BAUD_RATE(5000000), .CLK_FREQ(50000000), .FIFO_DEPTH(8)) u2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(din), .full(full_v[2]), .empty(empty_v[2]),
        .fifo_count(cnt8[2]), .overflow(ovf_v[2]), .tx(tx_v[2]), .busy(busy_v[2]));
    uart_tx_fifo #(.N(8), .M(2), .PARITY_MODE(0), .BAUD_RATE(5000000), .CLK_FREQ(50000000), .FIFO_DEPTH(8)) u3 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(din), .full(full_v[3]), .empty(empty_v[3]),
        .fifo_count(cnt8[3]), .overflow(ovf_v[3]), .tx(tx_v[3]), .busy(busy_v[3]));
    uart_tx_fifo #(.N(8), .M(1), .PARITY_MODE(0), .BAUD_RATE(5000000), .CLK_FREQ(50000000), .FIFO_DEPTH(4)) u4 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(din), .full(full_v[4]), .empty(empty_v[4]),
        .fifo_count(cnt4), .overflow(ovf_v[4]), .tx(tx_v[4]), .busy(busy_v[4]));

    typedef struct {
        string      nm;
        int         inst;
        logic [7:0] data;
        int         nbits;
        bit [0:11]  seq;   // line bits in transmit order, index 0 = start bit
        int         len;
    } vec_t;

    vec_t       vecs [5];
    logic       line [700];
    logic [7:0] bytes6 [6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit chk);
        reset = 1'b0;
        wr_en = 1'b0;
        din   = 8'h00;
        step();
        step();
        if (chk) begin
            check("rst tx", {27'd0, tx_v}, 32'h1f);
            check("rst busy", {27'd0, busy_v}, 32'h0);
            check("rst empty", {27'd0, empty_v}, 32'h1f);
            check("rst full", {27'd0, full_v}, 32'h0);
            check("rst overflow", {27'd0, ovf_v}, 32'h0);
            check("rst count", {17'd0, cnt8[0], cnt8[1], cnt8[2], cnt4}, 32'h0);
        end
        reset = 1'b1;
        step();
    endtask

    // Called one cycle into a frame's start bit; checks each bit for all 10 cycles.
    task automatic check_frame(input int inst, input bit [0:11] seq, input int nbits,
                               input string nm, output int busy_cyc);
        busy_cyc = 0;
        for (int i = 0; i < nbits; i++) begin
            int hits = 0;
            for (int c = 0; c < 10; c++) begin
                if (tx_v[inst] === seq[i]) hits++;
                if (busy_v[inst] === 1'b1) busy_cyc++;
                step();
            end
            check($sformatf("%s bit%0d cycles", nm, i), hits, 10);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  b1, b2, n_busy;
        bit  done;
        logic [7:0] got;

        vecs[0] = '{nm: "aa_plain", inst: 0, data: 8'hAA, nbits: 10, seq: 12'b001010101100, len: 100};
        vecs[1] = '{nm: "07_even",  inst: 1, data: 8'h07, nbits: 11, seq: 12'b011100000110, len: 110};
        vecs[2] = '{nm: "07_odd",   inst: 2, data: 8'h07, nbits: 11, seq: 12'b011100000010, len: 110};
        vecs[3] = '{nm: "55_2stop", inst: 3, data: 8'h55, nbits: 11, seq: 12'b010101010110, len: 110};
        vecs[4] = '{nm: "3c_plain", inst: 0, data: 8'h3C, nbits: 10, seq: 12'b000111100100, len: 100};
        bytes6  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        do_reset(1'b1);

        // Single frames from the table
        for (int v = 0; v < 5; v++) begin
            if (v != 0) do_reset(1'b0);
            wr_en = 1'b1;
            din   = vecs[v].data;
            step();
            wr_en = 1'b0;
            check({vecs[v].nm, " idle after write edge"}, tx_v[vecs[v].inst], 1'b1);
            step();
            check_frame(vecs[v].inst, vecs[v].seq, vecs[v].nbits, vecs[v].nm, b1);
            check({vecs[v].nm, " busy cycles"}, b1, vecs[v].len);
            check({vecs[v].nm, " busy low after"}, busy_v[vecs[v].inst], 1'b0);
            check({vecs[v].nm, " tx high after"}, tx_v[vecs[v].inst], 1'b1);
        end

        // Back-to-back frames with two stop bits
        do_reset(1'b0);
        wr_en = 1'b1;
        din   = 8'h55;
        step();
        din   = 8'hCC;
        step();
        wr_en = 1'b0;
        check("b2b count push+pop", cnt8[3], 4'd1);
        check_frame(3, 12'b010101010110, 11, "b2b f1", b1);
        check_frame(3, 12'b000110011110, 11, "b2b f2", b2);
        check("b2b busy cycles", b1 + b2, 220);
        check("b2b busy low after", busy_v[3], 1'b0);

        // Depth-4 FIFO filled by 6 consecutive writes; line[0] is sampled after edge 1
        do_reset(1'b0);
        n_busy = 0;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1;
            din   = bytes6[i];
            step();
            line[i] = tx_v[4];
            if (busy_v[4] === 1'b1) n_busy++;
            case (i)
                0: begin
                    check("d4 edge1 count", cnt4, 3'd1);
                    check("d4 edge1 tx", tx_v[4], 1'b1);
                end
                1: begin
                    check("d4 edge2 popped tx", tx_v[4], 1'b0);
                    check("d4 edge2 count", cnt4, 3'd1);
                end
                4: begin
                    check("d4 edge5 full", full_v[4], 1'b1);
                    check("d4 edge5 count", cnt4, 3'd4);
                end
                5: begin
                    check("d4 edge6 overflow", ovf_v[4], 1'b1);
                    check("d4 edge6 count", cnt4, 3'd4);
                end
                default: ;
            endcase
        end
        wr_en = 1'b0;
        done  = 1'b0;
        for (int t = 6; t < 700; t++) begin
            step();
            line[t] = tx_v[4];
            if (t == 6) check("d4 overflow one cycle", ovf_v[4], 1'b0);
            if (busy_v[4] !== 1'b1) begin
                done = 1'b1;
                break;
            end
            n_busy++;
        end
        check("d4 finished in bound", done, 1'b1);
        check("d4 busy cycles (5 frames)", n_busy, 500);
        check("d4 empty at end", empty_v[4], 1'b1);
        for (int f = 0; f < 5; f++) begin
            got = 8'h00;
            for (int k = 0; k < 8; k++) got[k] = line[1 + 100*f + 10*(1 + k) + 5];
            check($sformatf("d4 frame%0d data", f), got, bytes6[f]);
        end

        // Reset mid-frame with a second byte queued
        do_reset(1'b0);
        wr_en = 1'b1;
        din   = 8'hFF;
        step();
        din   = 8'h12;
        step();
        wr_en = 1'b0;
        repeat (35) step();
        check("rmid busy before", busy_v[0], 1'b1);
        check("rmid count before", cnt8[0], 4'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rmid tx async", tx_v[0], 1'b1);
        check("rmid busy async", busy_v[0], 1'b0);
        check("rmid count async", cnt8[0], 4'd0);
        check("rmid empty async", empty_v[0], 1'b1);
        step();
        reset = 1'b1;
        b1 = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (tx_v[0] === 1'b1 && busy_v[0] === 1'b0) b1++;
        end
        check("rmid quiet cycles", b1, 60);
        wr_en = 1'b1;
        din   = 8'h3C;
        step();
        wr_en = 1'b0;
        check("rmid new write tx high", tx_v[0], 1'b1);
        step();
        check("rmid new write tx low", tx_v[0], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
